sprite_rom_arbiter: RTL

//  Shares one synchronous sprite ROM read port (11-bit address, 6-bit palette index)

---
 rtl/sprite_rom_arbiter.sv | 107 ++++++++++
 1 files changed

// File: rtl/sprite_rom_arbiter.sv
// Round-robin arbiter sharing one synchronous sprite ROM read port between NUM_REQ drawers.
// Optional per-requester stall counters are built when ARB_STALL_CNT_EN is defined.
module sprite_rom_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 11,
    parameter int DATA_W  = 6,
    parameter int ROM_LAT = 1
) (
    input  logic                      vga_clk,
    input  logic                      reset_n,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [ADDR_W-1:0]         rom_address,
    input  logic [DATA_W-1:0]         rom_q,
    output logic [NUM_REQ-1:0]        rd_valid,
    output logic [DATA_W-1:0]         rd_data,
    output logic [NUM_REQ*16-1:0]     stall_cnt,
    input  logic                      stall_clr
);

    localparam int PTR_W = $clog2(NUM_REQ);

    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [PTR_W-1:0]   win_idx;
    logic [PTR_W-1:0]   cand;
    logic               win_found;
    logic [NUM_REQ-1:0] win_oh;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [NUM_REQ-1:0] pipe_q [ROM_LAT];

    // Scan starts one past the last winner and wraps, so the last winner is checked last.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = PTR_W'((int'(ptr_q) + i) % NUM_REQ);
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    // Flops use the ungated winner; reset holds them anyway, only the output is masked.
    always_comb begin
        win_oh      = win_found ? (NUM_REQ'(1) << win_idx) : '0;
        gnt         = reset_n ? win_oh : '0;
        ptr_d       = win_found ? win_idx : ptr_q;
        addr_d      = win_found ? req_addr[int'(win_idx)*ADDR_W +: ADDR_W] : addr_q;
        rom_address = addr_d;
    end

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr_q  <= PTR_W'(NUM_REQ - 1);
            addr_q <= '0;
            for (int i = 0; i < ROM_LAT; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            ptr_q     <= ptr_d;
            addr_q    <= addr_d;
            pipe_q[0] <= win_oh;
            for (int i = 1; i < ROM_LAT; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    assign rd_valid = pipe_q[ROM_LAT-1];
    assign rd_data  = rom_q;

`ifdef ARB_STALL_CNT_EN
    logic [15:0] cnt_q [NUM_REQ];

    // Clear has priority over a same-cycle increment; counts saturate rather than wrap.
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (stall_clr) begin
                    cnt_q[i] <= '0;
                end else if (req[i] && !win_oh[i] && cnt_q[i] != 16'hFFFF) begin
                    cnt_q[i] <= cnt_q[i] + 16'd1;
                end
            end
        end
    end

    always_comb begin
        stall_cnt = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            stall_cnt[i*16 +: 16] = cnt_q[i];
        end
    end
`else
    logic unused_stall_clr;
    assign unused_stall_clr = stall_clr;
    assign stall_cnt        = '0;
`endif

endmodule
